// File: rtl/icache_pkg.sv
// Shared types and address-field helpers for the direct-mapped instruction cache.
// Field widths depend on SETS/LINE_WORDS, so they are computed by functions.
package icache_pkg;

    localparam int unsigned DATA_SIZE      = 32;
    localparam int unsigned ADDR_W         = 32;
    localparam int unsigned BYTE_W         = 2;
    localparam int unsigned DEF_SETS       = 64;
    localparam int unsigned DEF_LINE_WORDS = 4;

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        FILL,
        RESP
    } state_t;

    // Byte-offset width of a whole line (byte bits + word-select bits).
    function automatic int unsigned offset_w(input int unsigned line_words);
        return BYTE_W + $clog2(line_words);
    endfunction

    // Tag width left over once byte, word and index fields are removed.
    function automatic int unsigned tag_w(input int unsigned sets, input int unsigned line_words);
        return ADDR_W - offset_w(line_words) - $clog2(sets);
    endfunction

    // Line-aligned address: clear the low off_w bits.
    function automatic logic [ADDR_W-1:0] line_addr(input logic [ADDR_W-1:0] addr,
                                                    input int unsigned off_w);
        logic [ADDR_W-1:0] mask;
        mask = '1;
        mask = mask << off_w;
        return addr & mask;
    endfunction

endpackage

// File: rtl/icache_if.sv
// PC stage <-> I-cache fetch interface. The PC stage is the master,
// the cache controller is the slave (responder).
interface icache_if;
    import icache_pkg::*;

    logic [ADDR_W-1:0]    req_addr;
    logic                 req_en;
    logic [DATA_SIZE-1:0] inst;
    logic                 hit;
    logic                 istall;

    modport master (output req_addr, req_en, input inst, hit, istall);
    modport slave  (input req_addr, req_en, output inst, hit, istall);

endinterface

// File: rtl/icache_line_array.sv
// Flop-based line storage: valid, tag and data words per set.
// One write port (word write, tag+valid on the last beat), bulk invalidate,
// combinational read.
module icache_line_array
    import icache_pkg::*;
#(
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS,
    parameter int unsigned TAG_W      = tag_w(DEF_SETS, DEF_LINE_WORDS)
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          inval,
    input  logic                          wr_en,
    input  logic                          wr_last,
    input  logic [$clog2(SETS)-1:0]       wr_index,
    input  logic [$clog2(LINE_WORDS)-1:0] wr_word,
    input  logic [TAG_W-1:0]              wr_tag,
    input  logic [DATA_SIZE-1:0]          wr_data,
    input  logic [$clog2(SETS)-1:0]       rd_index,
    input  logic [$clog2(LINE_WORDS)-1:0] rd_word,
    output logic                          rd_valid,
    output logic [TAG_W-1:0]              rd_tag,
    output logic [DATA_SIZE-1:0]          rd_data
);

    logic [SETS-1:0]      valid;
    logic [TAG_W-1:0]     tag_mem  [SETS];
    logic [DATA_SIZE-1:0] data_mem [SETS][LINE_WORDS];

    // Valid bits: reset/invalidate clear all, last refill beat sets one.
    always_ff @(posedge clk) begin
        if (rst || inval) begin
            valid <= '0;
        end else if (wr_en && wr_last) begin
            valid[wr_index] <= 1'b1;
        end
    end

    // Tag and data storage; no reset needed since valid guards them.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_mem[wr_index][wr_word] <= wr_data;
            if (wr_last) begin
                tag_mem[wr_index] <= wr_tag;
            end
        end
    end

    assign rd_valid = valid[rd_index];
    assign rd_tag   = tag_mem[rd_index];
    assign rd_data  = data_mem[rd_index][rd_word];

endmodule

// File: rtl/icache_ctrl.sv
// Direct-mapped instruction cache controller: combinational lookup, single-line
// refill FSM (IDLE/REQ/FILL/RESP) and deferred flush during refill.
// Optional: define ICACHE_PERF_EN to build the hit/miss counters.
module icache_ctrl
    import icache_pkg::*;
#(
    parameter int unsigned SETS       = DEF_SETS,
    parameter int unsigned LINE_WORDS = DEF_LINE_WORDS
) (
    input  logic                 clk,
    input  logic                 rst,
    icache_if.slave              fetch,
    input  logic                 flush,
    output logic                 mem_req,
    output logic [ADDR_W-1:0]    mem_addr,
    input  logic                 mem_ready,
    input  logic                 mem_rvalid,
    input  logic [DATA_SIZE-1:0] mem_rdata,
    output logic [31:0]          hit_cnt,
    output logic [31:0]          miss_cnt
);

    localparam int unsigned WORD_W  = $clog2(LINE_WORDS);
    localparam int unsigned INDEX_W = $clog2(SETS);
    localparam int unsigned OFF_W   = offset_w(LINE_WORDS);
    localparam int unsigned TAG_W   = tag_w(SETS, LINE_WORDS);
    localparam logic [WORD_W-1:0] LAST_BEAT = WORD_W'(LINE_WORDS - 1);

    state_t                   state, state_nx;
    logic [ADDR_W-1:BYTE_W]   miss_addr;
    logic [WORD_W-1:0]        beat_cnt;
    logic                     flush_pend;

    logic                     rd_valid;
    logic [TAG_W-1:0]         rd_tag;
    logic [DATA_SIZE-1:0]     rd_data;
    logic [INDEX_W-1:0]       rd_index;
    logic [WORD_W-1:0]        rd_word;
    logic                     lookup_hit;

    logic                     wr_en, wr_last, inval, miss_latch;
    logic                     count_hit, count_miss;
    logic [DATA_SIZE-1:0]     inst_c;
    logic                     hit_c, istall_c;
    logic                     unused_byte;

    assign unused_byte = ^fetch.req_addr[BYTE_W-1:0];

    // The single read port serves the lookup in IDLE and the miss word otherwise.
    assign rd_index   = (state == IDLE) ? fetch.req_addr[OFF_W +: INDEX_W] : miss_addr[OFF_W +: INDEX_W];
    assign rd_word    = (state == IDLE) ? fetch.req_addr[BYTE_W +: WORD_W] : miss_addr[BYTE_W +: WORD_W];
    assign lookup_hit = rd_valid && (rd_tag == fetch.req_addr[ADDR_W-1 -: TAG_W]);

    icache_line_array #(
        .SETS       (SETS),
        .LINE_WORDS (LINE_WORDS),
        .TAG_W      (TAG_W)
    ) u_lines (
        .clk      (clk),
        .rst      (rst),
        .inval    (inval),
        .wr_en    (wr_en),
        .wr_last  (wr_last),
        .wr_index (miss_addr[OFF_W +: INDEX_W]),
        .wr_word  (beat_cnt),
        .wr_tag   (miss_addr[ADDR_W-1 -: TAG_W]),
        .wr_data  (mem_rdata),
        .rd_index (rd_index),
        .rd_word  (rd_word),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data)
    );

    // Next-state and outputs; everything is held idle while rst is high.
    always_comb begin
        state_nx   = state;
        inst_c     = '0;
        hit_c      = 1'b0;
        istall_c   = 1'b0;
        mem_req    = 1'b0;
        mem_addr   = '0;
        wr_en      = 1'b0;
        wr_last    = 1'b0;
        inval      = 1'b0;
        miss_latch = 1'b0;
        count_hit  = 1'b0;
        count_miss = 1'b0;
        if (!rst) begin
            case (state)
                IDLE: begin
                    inval = flush;
                    if (fetch.req_en) begin
                        if (lookup_hit) begin
                            inst_c    = rd_data;
                            hit_c     = 1'b1;
                            count_hit = 1'b1;
                        end else begin
                            istall_c   = 1'b1;
                            miss_latch = 1'b1;
                            count_miss = 1'b1;
                            state_nx   = REQ;
                        end
                    end
                end
                REQ: begin
                    istall_c = 1'b1;
                    mem_req  = 1'b1;
                    mem_addr = line_addr({miss_addr, {BYTE_W{1'b0}}}, OFF_W);
                    if (mem_ready) begin
                        state_nx = FILL;
                    end
                end
                FILL: begin
                    istall_c = 1'b1;
                    if (mem_rvalid) begin
                        wr_en = 1'b1;
                        if (beat_cnt == LAST_BEAT) begin
                            wr_last  = 1'b1;
                            state_nx = RESP;
                        end
                    end
                end
                RESP: begin
                    inst_c   = rd_data;
                    inval    = flush || flush_pend;
                    state_nx = IDLE;
                end
                default: state_nx = IDLE;
            endcase
        end
    end

    assign fetch.inst   = inst_c;
    assign fetch.hit    = hit_c;
    assign fetch.istall = istall_c;

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    // Capture the missing fetch address (byte bits dropped).
    always_ff @(posedge clk) begin
        if (miss_latch) begin
            miss_addr <= fetch.req_addr[ADDR_W-1:BYTE_W];
        end
    end

    // Beat counter: cleared while requesting, advanced per accepted beat.
    always_ff @(posedge clk) begin
        if (rst || state == REQ) begin
            beat_cnt <= '0;
        end else if (wr_en) begin
            beat_cnt <= beat_cnt + WORD_W'(1);
        end
    end

    // Flush seen mid-refill is deferred until the RESP->IDLE edge.
    always_ff @(posedge clk) begin
        if (rst || state == RESP) begin
            flush_pend <= 1'b0;
        end else if (flush && (state == REQ || state == FILL)) begin
            flush_pend <= 1'b1;
        end
    end

`ifdef ICACHE_PERF_EN
    // Free-running wrap-around hit/miss counters for IDLE lookups.
    always_ff @(posedge clk) begin
        if (rst) begin
            hit_cnt  <= '0;
            miss_cnt <= '0;
        end else begin
            if (count_hit) begin
                hit_cnt <= hit_cnt + 32'd1;
            end
            if (count_miss) begin
                miss_cnt <= miss_cnt + 32'd1;
            end
        end
    end
`else
    logic unused_perf;
    assign unused_perf = count_hit ^ count_miss;
    assign hit_cnt     = '0;
    assign miss_cnt    = '0;
`endif

endmodule

// File: tb/tb_icache_ctrl.sv
// Bench for icache_ctrl: directed table, hand sequences (reset mid-fill,
// back-to-back hits) and randomized fetches against a line-residency model.
module tb_icache_ctrl;
    import icache_pkg::*;

    localparam int FL_NONE   = -1;
    localparam int FL_LOOKUP = 100;
    localparam int FL_REQ    = 200;
    localparam int FL_RESP   = 300;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        mem_req;
    logic [31:0] mem_addr;
    logic        mem_ready = 1'b0;
    logic        mem_rvalid = 1'b0;
    logic [31:0] mem_rdata = '0;
    logic [31:0] hit_cnt, miss_cnt;

    icache_if fetch_bus();

    icache_ctrl #(.SETS(64), .LINE_WORDS(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .fetch      (fetch_bus),
        .flush      (flush),
        .mem_req    (mem_req),
        .mem_addr   (mem_addr),
        .mem_ready  (mem_ready),
        .mem_rvalid (mem_rvalid),
        .mem_rdata  (mem_rdata),
        .hit_cnt    (hit_cnt),
        .miss_cnt   (miss_cnt)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference: backing memory plus which line number each set holds.
    logic [31:0] mem [logic [31:0]];
    bit          mvalid [64];
    int unsigned mline  [64];
    int unsigned mhits = 0;
    int unsigned mmiss = 0;

    typedef struct {
        logic [31:0] addr;
        int          dly;
        int          flush_at;
        bit          exp_hit;
        logic [31:0] exp_inst;
    } vec_t;

    vec_t vecs [10];

    function automatic logic [31:0] memrd(input logic [31:0] a);
        if (mem.exists(a)) return mem[a];
        return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
    endfunction

    task automatic chk1(input string nm, input logic act, input logic exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        foreach (mvalid[i]) mvalid[i] = 1'b0;
    endtask

    task automatic chk_counters();
        logic [31:0] eh, em;
`ifdef ICACHE_PERF_EN
        eh = mhits;
        em = mmiss;
`else
        eh = '0;
        em = '0;
`endif
        chk32("hit_cnt", hit_cnt, eh);
        chk32("miss_cnt", miss_cnt, em);
    endtask

    // One fetch transaction driven cycle by cycle, acting as PC stage and memory.
    task automatic fetch(input logic [31:0] a, input int dly, input int gap_max,
                         input int flush_at, input int rst_beat,
                         input bit use_exp, input bit exp_hit, input logic [31:0] exp_inst);
        int unsigned ln, st;
        bit          mh, pend;
        int          g;
        logic [31:0] wa, lb;
        wa = a & 32'hFFFF_FFFC;
        ln = a >> 4;
        st = ln % 64;
        lb = ln << 4;
        mh = mvalid[st] && (mline[st] == ln);
        pend = 1'b0;

        fetch_bus.req_addr = a;
        fetch_bus.req_en   = 1'b1;
        flush = (flush_at == FL_LOOKUP);
        @(negedge clk);
        chk1("lookup_hit", fetch_bus.hit, mh);
        chk1("lookup_istall", fetch_bus.istall, !mh);
        if (mh) chk32("lookup_inst", fetch_bus.inst, memrd(wa));
        if (use_exp) chk1("tbl_hit", fetch_bus.hit, exp_hit);
        if (use_exp && exp_hit) chk32("tbl_inst", fetch_bus.inst, exp_inst);
        @(posedge clk); #1;
        fetch_bus.req_en = 1'b0;
        flush = 1'b0;
        if (flush_at == FL_LOOKUP) model_clear();
        if (mh) begin
            mhits++;
            chk_counters();
            return;
        end
        mmiss++;

        for (int k = 0; k <= dly; k++) begin
            mem_ready = (k == dly);
            flush = (flush_at == FL_REQ) && (k == 0);
            @(negedge clk);
            chk1("req_mem_req", mem_req, 1'b1);
            chk32("req_mem_addr", mem_addr, lb);
            chk1("req_istall", fetch_bus.istall, 1'b1);
            @(posedge clk); #1;
        end
        if (flush_at == FL_REQ) pend = 1'b1;
        mem_ready = 1'b0;
        flush = 1'b0;

        for (int b = 0; b < 4; b++) begin
            g = (gap_max > 0) ? int'($urandom_range(0, gap_max)) : 0;
            repeat (g) begin
                mem_rvalid = 1'b0;
                mem_rdata  = $urandom;
                @(negedge clk);
                chk1("gap_istall", fetch_bus.istall, 1'b1);
                chk1("gap_mem_req", mem_req, 1'b0);
                @(posedge clk); #1;
            end
            mem_rvalid = 1'b1;
            mem_rdata  = memrd(lb + 32'(4 * b));
            flush = (flush_at == b);
            rst   = (rst_beat == b);
            @(negedge clk);
            if (rst_beat == b) begin
                chk1("rst_istall", fetch_bus.istall, 1'b0);
                chk1("rst_mem_req", mem_req, 1'b0);
            end else begin
                chk1("fill_istall", fetch_bus.istall, 1'b1);
                chk1("fill_mem_req", mem_req, 1'b0);
            end
            @(posedge clk); #1;
            mem_rvalid = 1'b0;
            flush = 1'b0;
            if (rst_beat == b) begin
                rst = 1'b0;
                model_clear();
                mhits = 0;
                mmiss = 0;
                return;
            end
            if (flush_at == b) pend = 1'b1;
        end

        flush = (flush_at == FL_RESP);
        @(negedge clk);
        chk1("resp_istall", fetch_bus.istall, 1'b0);
        chk1("resp_hit", fetch_bus.hit, 1'b0);
        chk32("resp_inst", fetch_bus.inst, memrd(wa));
        chk1("resp_mem_req", mem_req, 1'b0);
        if (use_exp) chk32("tbl_resp_inst", fetch_bus.inst, exp_inst);
        @(posedge clk); #1;
        flush = 1'b0;
        mvalid[st] = 1'b1;
        mline[st]  = ln;
        if (pend || flush_at == FL_RESP) model_clear();
        chk_counters();
    endtask

    task automatic chk_idle_outputs(input string tag);
        chk1({tag, "_hit"}, fetch_bus.hit, 1'b0);
        chk1({tag, "_istall"}, fetch_bus.istall, 1'b0);
        chk32({tag, "_inst"}, fetch_bus.inst, 32'h0);
        chk1({tag, "_mem_req"}, mem_req, 1'b0);
        chk32({tag, "_mem_addr"}, mem_addr, 32'h0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] snap, exp_delta, a;
        int          fa, r;

        fetch_bus.req_addr = '0;
        fetch_bus.req_en   = 1'b0;
        model_clear();
        for (int w = 0; w < 4; w++) begin
            mem[32'h100 + 32'(4 * w)] = 32'h11 * 32'(w + 1);
            mem[32'h000 + 32'(4 * w)] = 32'hA0 + 32'(w);
            mem[32'h400 + 32'(4 * w)] = 32'hB0 + 32'(w);
            mem[32'h200 + 32'(4 * w)] = 32'hC0 + 32'(w);
        end

        vecs[0] = '{32'h0000_0100, 0, FL_NONE, 1'b0, 32'h11};
        vecs[1] = '{32'h0000_0108, 0, FL_NONE, 1'b1, 32'h33};
        vecs[2] = '{32'h0000_0104, 0, FL_NONE, 1'b1, 32'h22};
        vecs[3] = '{32'h0000_0000, 0, FL_NONE, 1'b0, 32'hA0};
        vecs[4] = '{32'h0000_0400, 5, FL_NONE, 1'b0, 32'hB0};
        vecs[5] = '{32'h0000_0000, 0, FL_NONE, 1'b0, 32'hA0};
        vecs[6] = '{32'h0000_000C, 0, FL_NONE, 1'b1, 32'hA3};
        vecs[7] = '{32'h0000_0208, 0, 1,       1'b0, 32'hC2};
        vecs[8] = '{32'h0000_0208, 0, FL_NONE, 1'b0, 32'hC2};
        vecs[9] = '{32'h0000_0100, 0, FL_NONE, 1'b0, 32'h11};

        // Reset: outputs idle during and after reset, counters cleared.
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_idle_outputs("in_reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        chk_idle_outputs("post_reset");
        chk32("reset_hit_cnt", hit_cnt, 32'h0);
        chk32("reset_miss_cnt", miss_cnt, 32'h0);
        @(posedge clk); #1;

        // Directed table.
        snap = '0;
        for (int i = 0; i < 10; i++) begin
            if (i == 3) snap = miss_cnt;
            fetch(vecs[i].addr, vecs[i].dly, 0, vecs[i].flush_at, -1,
                  1'b1, vecs[i].exp_hit, vecs[i].exp_inst);
            if (i == 5) begin
`ifdef ICACHE_PERF_EN
                exp_delta = 32'd3;
`else
                exp_delta = 32'd0;
`endif
                chk32("conflict_miss_delta", miss_cnt - snap, exp_delta);
            end
        end

        // Back-to-back hits across the 0x200 line with req_en held high.
        snap = hit_cnt;
        for (int w = 0; w < 4; w++) begin
            fetch_bus.req_addr = 32'h200 + 32'(4 * w);
            fetch_bus.req_en   = 1'b1;
            @(negedge clk);
            chk1("b2b_hit", fetch_bus.hit, 1'b1);
            chk1("b2b_istall", fetch_bus.istall, 1'b0);
            chk32("b2b_inst", fetch_bus.inst, 32'hC0 + 32'(w));
            @(posedge clk); #1;
        end
        fetch_bus.req_en = 1'b0;
        mhits += 4;
`ifdef ICACHE_PERF_EN
        exp_delta = 32'd4;
`else
        exp_delta = 32'd0;
`endif
        chk32("b2b_hit_delta", hit_cnt - snap, exp_delta);

        // Reset during the third fill beat, then stray beats, then refetch misses.
        fetch(32'h0000_0300, 0, 0, FL_NONE, 2, 1'b0, 1'b0, 32'h0);
        @(negedge clk);
        chk_idle_outputs("after_abort");
        chk_counters();
        @(posedge clk); #1;
        repeat (3) begin
            mem_rvalid = 1'b1;
            mem_rdata  = $urandom;
            @(negedge clk);
            chk_idle_outputs("stray_beat");
            @(posedge clk); #1;
        end
        mem_rvalid = 1'b0;
        fetch(32'h0000_0300, 0, 0, FL_NONE, -1, 1'b1, 1'b0, memrd(32'h300));

        // Randomized fetches over a few conflicting sets, with flushes at every phase.
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 9) == 0) begin
                fetch_bus.req_en = 1'b0;
                flush = 1'b1;
                @(negedge clk);
                chk1("idle_flush_hit", fetch_bus.hit, 1'b0);
                chk1("idle_flush_istall", fetch_bus.istall, 1'b0);
                chk32("idle_flush_inst", fetch_bus.inst, 32'h0);
                @(posedge clk); #1;
                flush = 1'b0;
                model_clear();
            end
            a = (32'($urandom_range(0, 2)) << 10) | (32'($urandom_range(0, 3)) << 4)
              | (32'($urandom_range(0, 3)) << 2) | 32'($urandom_range(0, 3));
            r = int'($urandom_range(0, 24));
            case (r)
                0:       fa = FL_LOOKUP;
                1:       fa = FL_REQ;
                2:       fa = FL_RESP;
                3:       fa = int'($urandom_range(0, 3));
                default: fa = FL_NONE;
            endcase
            fetch(a, int'($urandom_range(0, 3)), 2, fa, -1, 1'b0, 1'b0, 32'h0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
